// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, FSM states, requester ids and address slicing for the refill controller
package cache_pkg;

    localparam int ADDR_W = 32;
    localparam int TAG_W  = 24;
    localparam int IDX_W  = 5;
    localparam int OFF_W  = 3;
    localparam int LINE_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        FILL    = 2'd2,
        RECOVER = 2'd3
    } state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr_of(input logic [TAG_W-1:0] tag,
                                                       input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter between I and D refill requests
module rr_arb2
    import cache_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic req_d,
    input  logic grant_en,
    output logic gnt_valid,
    output logic gnt_id
);

    logic last_grant;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        gnt_valid = req_i | req_d;
        gnt_id    = REQ_I;
        if (req_i && req_d) begin
            gnt_id = ~last_grant;
        end else if (req_d) begin
            gnt_id = REQ_D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= REQ_I;
        end else if (grant_en && gnt_valid) begin
            last_grant <= gnt_id;
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - I/D cache line refill sequencer over one shared memory read port
module cache_refill_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_data,
    output logic [LINE_W-1:0] fill_data,
    output logic [IDX_W-1:0]  fill_idx,
    output logic [TAG_W-1:0]  fill_tag,
    output logic              i_fill,
    output logic              d_fill,
    output logic              i_stall,
    output logic              d_stall,
    output logic              busy
);

    state_t            state_q, state_d;
    logic              owner_q;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic              gnt_valid;
    logic              gnt_id;
    logic              grant_en;
    logic [ADDR_W-1:0] gnt_addr;
    logic              unused_offset;

    // Byte offsets never reach the memory request; lines are fetched whole.
    assign unused_offset = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

    assign grant_en = (state_q == IDLE);
    assign gnt_addr = (gnt_id == REQ_D) ? d_addr : i_addr;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (i_miss),
        .req_d     (d_miss),
        .grant_en  (grant_en),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_valid) state_d = REQ;
            REQ:     if (mem_ack) state_d = FILL;
            FILL:    state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= REQ_I;
            tag_q     <= '0;
            idx_q     <= '0;
            fill_data <= '0;
        end else begin
            state_q <= state_d;
            if (grant_en && gnt_valid) begin
                owner_q <= gnt_id;
                tag_q   <= tag_of(gnt_addr);
                idx_q   <= idx_of(gnt_addr);
            end
            if (state_q == REQ && mem_ack) begin
                fill_data <= mem_data;
            end
        end
    end

    assign mem_req  = (state_q == REQ);
    assign mem_addr = line_addr_of(tag_q, idx_q);
    assign fill_idx = idx_q;
    assign fill_tag = tag_q;
    assign busy     = (state_q != IDLE);
    assign i_fill   = (state_q == FILL) && (owner_q == REQ_I);
    assign d_fill   = (state_q == FILL) && (owner_q == REQ_D);

    // The owner stays frozen through RECOVER so its tag lookup sees the new line.
    assign i_stall  = i_miss | (busy && owner_q == REQ_I);
    assign d_stall  = d_miss | (busy && owner_q == REQ_D);

endmodule
